sram_axi_slave: RTL and testbench

AXI4 slave front-end that sits directly upstream of the 16384×32 single-port SRAM macro and translates AXI read/write bursts into the macro's CEB/WEB/A/D/BWEB strobes. It also returns the macro's Q as R-channel data. It serves one transaction at a time: a read burst or a write burst, never both. It is the slave-side stage between the bus interconnect and the SRAM in the memory subsystem.

---
 rtl/sram_axi_slave.sv | 203 ++++++++++++++++++++
 tb/tb_sram_axi_slave.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_slave.sv
// AXI4 slave front-end for a single-port 32-bit SRAM macro: one read or write
// burst at a time, translated into CEB/WEB/A/D/BWEB strobes with Q returned on R.
module sram_axi_slave #(
  parameter int ID_W    = 8,
  parameter int SRAM_AW = 14
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  // write address
  input  logic [ID_W-1:0]    AWID,
  input  logic [31:0]        AWADDR,
  input  logic [3:0]         AWLEN,
  input  logic [2:0]         AWSIZE,
  input  logic [1:0]         AWBURST,
  input  logic               AWVALID,
  output logic               AWREADY,
  // write data
  input  logic [31:0]        WDATA,
  input  logic [3:0]         WSTRB,
  input  logic               WLAST,
  input  logic               WVALID,
  output logic               WREADY,
  // write response
  output logic [ID_W-1:0]    BID,
  output logic [1:0]         BRESP,
  output logic               BVALID,
  input  logic               BREADY,
  // read address
  input  logic [ID_W-1:0]    ARID,
  input  logic [31:0]        ARADDR,
  input  logic [3:0]         ARLEN,
  input  logic [2:0]         ARSIZE,
  input  logic [1:0]         ARBURST,
  input  logic               ARVALID,
  output logic               ARREADY,
  // read data
  output logic [ID_W-1:0]    RID,
  output logic [31:0]        RDATA,
  output logic [1:0]         RRESP,
  output logic               RLAST,
  output logic               RVALID,
  input  logic               RREADY,
  // SRAM macro
  output logic               CEB,
  output logic               WEB,
  output logic [SRAM_AW-1:0] A,
  output logic [31:0]        D,
  output logic [31:0]        BWEB,
  input  logic [31:0]        Q
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_WRESP = 2'd3;

  localparam logic [SRAM_AW-1:0] ADDR_ONE = {{(SRAM_AW-1){1'b0}}, 1'b1};

  logic [1:0]         state_reg, state_next;
  logic               last_grant_reg, last_grant_next;  // 1: write was granted last
  logic [ID_W-1:0]    id_reg, id_next;
  logic [3:0]         len_reg, len_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic [SRAM_AW-1:0] addr_reg, addr_next;
  logic               err_reg, err_next;

  logic               grant_r, grant_w;
  logic               last_beat;
  logic [31:0]        bweb_beat;

  // Size, burst type and address bits outside the window are accepted but ignored.
  logic unused_inputs;
  assign unused_inputs = ^{AWSIZE, AWBURST, ARSIZE, ARBURST,
                           AWADDR[31:SRAM_AW+2], AWADDR[1:0],
                           ARADDR[31:SRAM_AW+2], ARADDR[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bweb
      assign bweb_beat[8*gi +: 8] = {8{~WSTRB[gi]}};
    end
  endgenerate

  // Round-robin only matters on a tie; a lone request always wins.
  assign grant_r   = ARVALID & (~AWVALID | last_grant_reg);
  assign grant_w   = AWVALID & (~ARVALID | ~last_grant_reg);
  assign last_beat = (cnt_reg == len_reg);

  assign RDATA = Q;
  assign RID   = id_reg;
  assign RRESP = 2'b00;
  assign BID   = id_reg;
  assign BRESP = err_reg ? 2'b10 : 2'b00;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    id_next         = id_reg;
    len_next        = len_reg;
    cnt_next        = cnt_reg;
    addr_next       = addr_reg;
    err_next        = err_reg;
    AWREADY         = 1'b0;
    ARREADY         = 1'b0;
    WREADY          = 1'b0;
    BVALID          = 1'b0;
    RVALID          = 1'b0;
    RLAST           = 1'b0;
    CEB             = 1'b1;
    WEB             = 1'b1;
    A               = '0;
    D               = '0;
    BWEB            = '1;
    // Outputs are gated by reset so an in-flight burst drops its handshakes at once.
    if (ARESETn) begin
      case (state_reg)
        ST_IDLE: begin
          ARREADY = grant_r;
          AWREADY = grant_w;
          if (grant_r) begin
            CEB             = 1'b0;
            A               = ARADDR[SRAM_AW+1:2];
            id_next         = ARID;
            len_next        = ARLEN;
            addr_next       = ARADDR[SRAM_AW+1:2];
            cnt_next        = 4'd0;
            last_grant_next = 1'b0;
            state_next      = ST_READ;
          end else if (grant_w) begin
            id_next         = AWID;
            len_next        = AWLEN;
            addr_next       = AWADDR[SRAM_AW+1:2];
            cnt_next        = 4'd0;
            err_next        = 1'b0;
            last_grant_next = 1'b1;
            state_next      = ST_WRITE;
          end
        end
        ST_READ: begin
          RVALID = 1'b1;
          RLAST  = last_beat;
          if (RREADY) begin
            if (!last_beat) begin
              CEB       = 1'b0;
              A         = addr_reg + ADDR_ONE;
              addr_next = addr_reg + ADDR_ONE;
              cnt_next  = cnt_reg + 4'd1;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
        ST_WRITE: begin
          WREADY = 1'b1;
          if (WVALID) begin
            CEB       = 1'b0;
            WEB       = 1'b0;
            A         = addr_reg;
            D         = WDATA;
            BWEB      = bweb_beat;
            addr_next = addr_reg + ADDR_ONE;
            cnt_next  = cnt_reg + 4'd1;
            // A misplaced WLAST is flagged, but the beat count alone ends the burst.
            if (WLAST != last_beat) begin
              err_next = 1'b1;
            end
            if (last_beat) begin
              state_next = ST_WRESP;
            end
          end
        end
        ST_WRESP: begin
          BVALID = 1'b1;
          if (BREADY) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= 1'b1;
      id_reg         <= '0;
      len_reg        <= 4'd0;
      cnt_reg        <= 4'd0;
      addr_reg       <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      id_reg         <= id_next;
      len_reg        <= len_next;
      cnt_reg        <= cnt_next;
      addr_reg       <= addr_next;
      err_reg        <= err_next;
    end
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Directed bench for sram_axi_slave with a behavioural 16384x32 SRAM model on the strobes.
module tb_sram_axi_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA, D, BWEB, Q;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, CEB, WEB;
  logic [13:0] A;

  logic [31:0] mem [0:16383];
  int checks = 0;
  int errors = 0;
  logic [7:0] id_seq = 8'h10;

  always #5 ACLK = ~ACLK;

  sram_axi_slave #(.ID_W(8), .SRAM_AW(14)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CEB(CEB), .WEB(WEB), .A(A), .D(D), .BWEB(BWEB), .Q(Q)
  );

  // SRAM macro: masked write, or registered read whose Q holds until the next read.
  always @(posedge ACLK) begin
    if (!CEB) begin
      if (!WEB) mem[A] <= (mem[A] & BWEB) | (D & ~BWEB);
      else      Q <= mem[A];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_bweb(input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? 8'h00 : 8'hFF;
    return r;
  endfunction

  task automatic wr(input logic [31:0] addr, input logic [3:0] len, input logic [31:0] d0,
                    input logic [31:0] dinc, input logic [3:0] strb, input bit bad_last,
                    input logic [1:0] exp_resp);
    int n;
    logic [13:0] a;
    logic [7:0] id;
    id = id_seq;
    id_seq = id_seq + 8'd1;
    @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = addr; AWLEN = len; AWID = id;
    #1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 20) begin @(negedge ACLK); #1; n++; end
    check("awready", {31'd0, AWREADY}, 32'd1);
    a = addr[15:2];
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge ACLK);
      AWVALID = 1'b0; WVALID = 1'b1; WDATA = d0 + i * dinc; WSTRB = strb;
      WLAST = bad_last ? (i == 0) : (i == int'(len));
      #1;
      check("wready", {31'd0, WREADY}, 32'd1);
      check("w_ceb", {31'd0, CEB}, 32'd0);
      check("w_web", {31'd0, WEB}, 32'd1 - 32'd1);
      check("w_addr", {18'd0, A}, {18'd0, a});
      check("w_d", D, d0 + i * dinc);
      check("w_bweb", BWEB, exp_bweb(strb));
      a = a + 14'd1;
    end
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    #1;
    check("bvalid", {31'd0, BVALID}, 32'd1);
    check("bresp", {30'd0, BRESP}, {30'd0, exp_resp});
    check("bid", {24'd0, BID}, {24'd0, id});
    check("wresp_ceb", {31'd0, CEB}, 32'd1);
    @(negedge ACLK);
    BREADY = 1'b0;
    $display("WRITE addr=0x%08h len=%0d strb=%b bresp=%b", addr, len, strb, BRESP);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [3:0] len, input logic [31:0] d0,
                    input logic [31:0] dinc, input bit stall);
    int n;
    logic [13:0] a;
    logic [7:0] id;
    id = id_seq;
    id_seq = id_seq + 8'd1;
    @(negedge ACLK);
    ARVALID = 1'b1; ARADDR = addr; ARLEN = len; ARID = id;
    #1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 20) begin @(negedge ACLK); #1; n++; end
    check("arready", {31'd0, ARREADY}, 32'd1);
    check("ar_ceb", {31'd0, CEB}, 32'd0);
    check("ar_web", {31'd0, WEB}, 32'd1);
    a = addr[15:2];
    check("ar_addr", {18'd0, A}, {18'd0, a});
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge ACLK);
      ARVALID = 1'b0;
      if (stall) begin
        RREADY = 1'b0;
        #1;
        check("stall_rvalid", {31'd0, RVALID}, 32'd1);
        check("stall_rdata", RDATA, d0 + i * dinc);
        check("stall_ceb", {31'd0, CEB}, 32'd1);
        check("stall_rlast", {31'd0, RLAST}, (i == int'(len)) ? 32'd1 : 32'd0);
        @(negedge ACLK);
      end
      RREADY = 1'b1;
      #1;
      check("rvalid", {31'd0, RVALID}, 32'd1);
      check("rdata", RDATA, d0 + i * dinc);
      check("rlast", {31'd0, RLAST}, (i == int'(len)) ? 32'd1 : 32'd0);
      check("rid", {24'd0, RID}, {24'd0, id});
      if (i < int'(len)) begin
        check("r_ceb", {31'd0, CEB}, 32'd0);
        check("r_addr", {18'd0, A}, {18'd0, a + 14'd1});
      end else begin
        check("rlast_ceb", {31'd0, CEB}, 32'd1);
      end
      a = a + 14'd1;
    end
    @(negedge ACLK);
    RREADY = 1'b0;
    #1;
    check("r_done", {31'd0, RVALID}, 32'd0);
    $display("READ  addr=0x%08h len=%0d stall=%0d last_rdata=0x%08h", addr, len, stall, Q);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
    Q = 32'd0;
    ARESETn = 1'b0;
    AWID = 8'd1; AWADDR = 32'h40; AWLEN = 4'd0; AWSIZE = 3'd2; AWBURST = 2'b01;
    ARID = 8'd2; ARADDR = 32'h80; ARLEN = 4'd0; ARSIZE = 3'd2; ARBURST = 2'b01;
    WDATA = 32'd0; WSTRB = 4'h0; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b0; RREADY = 1'b0;
    AWVALID = 1'b1; ARVALID = 1'b1;

    // Reset with both address channels requesting
    repeat (2) @(negedge ACLK);
    #1;
    check("rst_awready", {31'd0, AWREADY}, 32'd0);
    check("rst_arready", {31'd0, ARREADY}, 32'd0);
    check("rst_wready", {31'd0, WREADY}, 32'd0);
    check("rst_bvalid", {31'd0, BVALID}, 32'd0);
    check("rst_rvalid", {31'd0, RVALID}, 32'd0);
    check("rst_ceb", {31'd0, CEB}, 32'd1);
    check("rst_web", {31'd0, WEB}, 32'd1);
    check("rst_bweb", BWEB, 32'hFFFF_FFFF);

    // Arbitration: read first, then write, then read again
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    check("arb1_arready", {31'd0, ARREADY}, 32'd1);
    check("arb1_awready", {31'd0, AWREADY}, 32'd0);
    @(negedge ACLK);
    RREADY = 1'b1;
    #1;
    check("arb1_rvalid", {31'd0, RVALID}, 32'd1);
    check("arb1_rdata", RDATA, 32'd0);
    check("arb1_busy_aw", {31'd0, AWREADY}, 32'd0);
    @(negedge ACLK);
    RREADY = 1'b0;
    #1;
    check("arb2_awready", {31'd0, AWREADY}, 32'd1);
    check("arb2_arready", {31'd0, ARREADY}, 32'd0);
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b1; WDATA = 32'h0000_0055; WSTRB = 4'hF; WLAST = 1'b1;
    #1;
    check("arb2_wready", {31'd0, WREADY}, 32'd1);
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1; AWVALID = 1'b1; AWADDR = 32'h44;
    #1;
    check("arb2_bvalid", {31'd0, BVALID}, 32'd1);
    check("arb2_no_ar_on_b", {31'd0, ARREADY}, 32'd0);
    @(negedge ACLK);
    BREADY = 1'b0;
    #1;
    check("arb3_arready", {31'd0, ARREADY}, 32'd1);
    check("arb3_awready", {31'd0, AWREADY}, 32'd0);
    @(negedge ACLK);
    ARVALID = 1'b0; RREADY = 1'b1;
    #1;
    check("arb3_rvalid", {31'd0, RVALID}, 32'd1);
    @(negedge ACLK);
    RREADY = 1'b0;
    #1;
    check("arb4_awready", {31'd0, AWREADY}, 32'd1);
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b1; WDATA = 32'h0000_0066; WSTRB = 4'hF; WLAST = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    #1;
    check("arb4_bvalid", {31'd0, BVALID}, 32'd1);
    @(negedge ACLK);
    BREADY = 1'b0;
    $display("ARB   read, write, read, write sequence done");
    rd(32'h40, 4'd1, 32'h55, 32'h11, 1'b0);

    // Single write then read
    wr(32'h0000_0010, 4'd0, 32'hDEAD_BEEF, 32'd0, 4'hF, 1'b0, 2'b00);
    rd(32'h0000_0010, 4'd0, 32'hDEAD_BEEF, 32'd0, 1'b0);

    // Byte strobes
    wr(32'h20, 4'd0, 32'h1122_3344, 32'd0, 4'hF, 1'b0, 2'b00);
    wr(32'h20, 4'd0, 32'hAABB_CCDD, 32'd0, 4'b0101, 1'b0, 2'b00);
    rd(32'h20, 4'd0, 32'h11BB_33DD, 32'd0, 1'b0);

    // Wrapping burst with read backpressure
    wr(32'h0000_FFF8, 4'd3, 32'd0, 32'd1, 4'hF, 1'b0, 2'b00);
    rd(32'h0000_FFF8, 4'd3, 32'd0, 32'd1, 1'b1);

    // Early WLAST: both beats land, SLVERR returned
    wr(32'h100, 4'd1, 32'hA0, 32'd1, 4'hF, 1'b1, 2'b10);
    rd(32'h100, 4'd1, 32'hA0, 32'd1, 1'b0);

    // Reset during beat 2 of an 8-beat read
    wr(32'h200, 4'd7, 32'h100, 32'd1, 4'hF, 1'b0, 2'b00);
    @(negedge ACLK);
    ARVALID = 1'b1; ARADDR = 32'h200; ARLEN = 4'd7; ARID = 8'h77;
    #1;
    check("mid_arready", {31'd0, ARREADY}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      ARVALID = 1'b0; RREADY = 1'b1;
      #1;
      check("mid_rdata", RDATA, 32'h100 + i);
    end
    @(negedge ACLK);
    #1;
    check("mid_beat2", RDATA, 32'h102);
    ARESETn = 1'b0; RREADY = 1'b0;
    #1;
    check("mid_rst_rvalid", {31'd0, RVALID}, 32'd0);
    check("mid_rst_ceb", {31'd0, CEB}, 32'd1);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    check("post_rst_rvalid", {31'd0, RVALID}, 32'd0);
    check("post_rst_ceb", {31'd0, CEB}, 32'd1);
    $display("RESET mid-burst abort issued");
    rd(32'h208, 4'd2, 32'h102, 32'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
